// File: rtl/seq_divider32_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider32_pkg
//   Shared constants for the sequential integer divider.
//   Holds the controller state encodings (kept as fixed 2-bit codes so that
//   waveforms and any legacy tooling keyed on the numeric values still line
//   up) and the default operand / counter widths.
// -----------------------------------------------------------------------------
package seq_divider32_pkg;

   // Default datapath geometry.
   localparam int unsigned DIV_WIDTH_DEFAULT = 32;
   localparam int unsigned DIV_CNT_W_DEFAULT = 5;

   // Controller state encoding.
   typedef logic [1:0] div_state_t;

   localparam div_state_t DIV_IDLE = 2'd0;
   localparam div_state_t DIV_RUN  = 2'd1;
   localparam div_state_t DIV_FIX  = 2'd2;
   localparam div_state_t DIV_DONE = 2'd3;

endpackage : seq_divider32_pkg

// File: rtl/add32.sv
// -----------------------------------------------------------------------------
// add32
//   Ripple-style binary adder shared by the vALU datapath.
//   The width is a parameter so the divider can use it one bit wider than the
//   operands for its trial subtraction.
//
// Ports:
//   a, b  : addends (W bits)
//   cin   : carry in
//   sum   : a + b + cin, truncated to W bits
//   cout  : carry out of the most significant bit
// -----------------------------------------------------------------------------
module add32 #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] full;

   assign full        = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   assign {cout, sum} = full;

endmodule : add32

// File: rtl/negate32.sv
// -----------------------------------------------------------------------------
// negate32
//   Two's-complement negation: y = ~x + 1, built on the shared adder.
//   The most-negative value maps onto itself, which the divider relies on
//   when it forms the magnitude of a most-negative dividend.
//
// Ports:
//   x : value to negate (W bits)
//   y : -x (W bits)
// -----------------------------------------------------------------------------
module negate32 #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);

   logic unused_cout;

   add32 #(
      .W (W)
   ) u_add (
      .a    (~x),
      .b    ('0),
      .cin  (1'b1),
      .sum  (y),
      .cout (unused_cout)
   );

endmodule : negate32

// File: rtl/seq_divider32.sv
// -----------------------------------------------------------------------------
// seq_divider32
//   Multi-cycle restoring divider for the vALU datapath. One trial
//   subtraction per clock; fixed latency of WIDTH+2 clocks from the accepted
//   start edge to the done pulse, for every operand pair including B = 0.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   start      : launch request, only honoured in IDLE
//   ctlSigned  : 1 = two's-complement divide, 0 = unsigned
//   A, B       : dividend / divisor, captured on the accepted start edge
//   busy       : high from the cycle after an accepted start until done
//   done       : one-cycle pulse, results and flags valid
//   Quotient   : quotient truncated toward zero
//   Remainder  : remainder, sign follows the dividend
//   DivZero    : divisor was zero (Quotient = all ones, Remainder = A)
//   Overflow   : signed most-negative / -1
//
// Results and flags hold until the next accepted start; the flags clear on
// that start, the result words are rewritten when the new result is fixed up.
// -----------------------------------------------------------------------------
module seq_divider32
   import seq_divider32_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT,
   parameter int unsigned CNT_W = DIV_CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             ctlSigned,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivZero,
   output logic             Overflow
);

   localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WIDTH-1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // Controller and datapath state.
   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd;        // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs;        // divisor magnitude
   logic [WIDTH:0]   rem;        // partial remainder
   logic [WIDTH-1:0] dvd_orig;   // untouched A, returned on divide by zero
   logic             sign_a;
   logic             sign_b;
   logic             zero_div;
   logic             ovf;

   // Negator inputs: in IDLE they form |A| and |B| for the capture; in FIX
   // the same two negators sign-correct the quotient and remainder. No other
   // state uses their outputs, so one pair serves both jobs.
   logic             in_idle;
   logic [WIDTH-1:0] neg_in_a;
   logic [WIDTH-1:0] neg_in_b;
   logic [WIDTH-1:0] neg_out_a;
   logic [WIDTH-1:0] neg_out_b;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   // Trial subtraction.
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             trial_ok;

   // Remainder never reaches the divisor, so its top bit only serves as
   // headroom for the shifted value and is never read back.
   logic             unused_rem_msb;

   assign unused_rem_msb = rem[WIDTH];

   assign in_idle  = (state == DIV_IDLE);
   assign neg_in_a = in_idle ? A : dvd;
   assign neg_in_b = in_idle ? B : rem[WIDTH-1:0];

   negate32 #(
      .W (WIDTH)
   ) u_neg_q (
      .x (neg_in_a),
      .y (neg_out_a)
   );

   negate32 #(
      .W (WIDTH)
   ) u_neg_r (
      .x (neg_in_b),
      .y (neg_out_b)
   );

   assign mag_a = (ctlSigned && A[WIDTH-1]) ? neg_out_a : A;
   assign mag_b = (ctlSigned && B[WIDTH-1]) ? neg_out_b : B;

   // R' - divisor as R' + ~divisor + 1; carry out set means no borrow,
   // i.e. the trial result is non-negative.
   assign shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};

   add32 #(
      .W (WIDTH + 1)
   ) u_trial (
      .a    (shifted),
      .b    (~{1'b0, dvs}),
      .cin  (1'b1),
      .sum  (trial),
      .cout (trial_ok)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= DIV_IDLE;
         cnt       <= '0;
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         dvd_orig  <= '0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         zero_div  <= 1'b0;
         ovf       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         DivZero   <= 1'b0;
         Overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  dvd      <= mag_a;
                  dvs      <= mag_b;
                  rem      <= '0;
                  cnt      <= CNT_LOAD;
                  dvd_orig <= A;
                  sign_a   <= ctlSigned & A[WIDTH-1];
                  sign_b   <= ctlSigned & B[WIDTH-1];
                  zero_div <= (B == '0);
                  ovf      <= ctlSigned && (A == MOST_NEG) && (B == '1);
                  DivZero  <= 1'b0;
                  Overflow <= 1'b0;
                  busy     <= 1'b1;
                  state    <= DIV_RUN;
               end
            end

            DIV_RUN: begin
               rem <= trial_ok ? trial : shifted;
               dvd <= {dvd[WIDTH-2:0], trial_ok};
               if (cnt == '0) begin
                  state <= DIV_FIX;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            DIV_FIX: begin
               if (zero_div) begin
                  Quotient  <= '1;
                  Remainder <= dvd_orig;
               end else begin
                  Quotient  <= (sign_a ^ sign_b) ? neg_out_a : dvd;
                  Remainder <= sign_a ? neg_out_b : rem[WIDTH-1:0];
               end
               DivZero  <= zero_div;
               Overflow <= ovf;
               state    <= DIV_DONE;
            end

            DIV_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= DIV_IDLE;
            end

            default: begin
               state <= DIV_IDLE;
            end
         endcase
      end
   end

endmodule : seq_divider32

// File: tb/tb_seq_divider32.sv
// -----------------------------------------------------------------------------
// tb_seq_divider32
//   Directed, table-driven bench for seq_divider32 (WIDTH = 32), plus hand
//   sequences for the start-while-busy, reset-mid-operation and
//   reset-with-start cases.
// -----------------------------------------------------------------------------
module tb_seq_divider32;

   localparam int unsigned WIDTH   = 32;
   localparam int          LATENCY = WIDTH + 2;
   localparam int          NVEC    = 13;

   logic              clk;
   logic              reset;
   logic              start;
   logic              ctl_signed;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  quotient;
   logic [WIDTH-1:0]  remainder;
   logic              div_zero;
   logic              overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        ov;
   } vec_t;

   vec_t vecs[NVEC];

   seq_divider32 #(
      .WIDTH (32),
      .CNT_W (5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .ctlSigned (ctl_signed),
      .A         (a),
      .B         (b),
      .busy      (busy),
      .done      (done),
      .Quotient  (quotient),
      .Remainder (remainder),
      .DivZero   (div_zero),
      .Overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at the negedge after edge k+n0; counts further edges until done
   // is seen (bounded). n returns the edge offset from k at which done shows.
   task automatic wait_done(input int n0, output int n, output logic busy_ok);
      n       = n0;
      busy_ok = 1'b1;
      while (!done && n < 200) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic launch(input logic sg, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      ctl_signed = sg;
      a          = av;
      b          = bv;
      start      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start      = 1'b0;
      ctl_signed = ~sg;
      a          = $urandom;
      b          = $urandom;
   endtask

   task automatic run_vec(input vec_t v);
      int   n;
      logic bok;
      launch(v.sg, v.a, v.b);
      check({v.name, " flags clear at start"}, {30'd0, div_zero, overflow}, 32'd0);
      wait_done(0, n, bok);
      check({v.name, " latency"}, n, LATENCY);
      check({v.name, " busy throughout"}, {31'd0, bok}, 32'd1);
      check({v.name, " busy low at done"}, {31'd0, busy}, 32'd0);
      check({v.name, " quotient"}, quotient, v.q);
      check({v.name, " remainder"}, remainder, v.r);
      check({v.name, " divzero"}, {31'd0, div_zero}, {31'd0, v.dz});
      check({v.name, " overflow"}, {31'd0, overflow}, {31'd0, v.ov});
      @(posedge clk);
      @(negedge clk);
      check({v.name, " done one cycle"}, {31'd0, done}, 32'd0);
      check({v.name, " quotient holds"}, quotient, v.q);
   endtask

   initial begin
      int   n;
      int   done_seen;
      logic bok;

      vecs[0]  = '{"u 100/7",       1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0};
      vecs[1]  = '{"s -7/2",        1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[2]  = '{"s 7/-2",        1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0};
      vecs[3]  = '{"u 5/0",         1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0};
      vecs[4]  = '{"s 5/0",         1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0};
      vecs[5]  = '{"s min/-1",      1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1};
      vecs[6]  = '{"u min/max",     1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0};
      vecs[7]  = '{"u max/1",       1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0};
      vecs[8]  = '{"s -100/-7",     1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[9]  = '{"u 6/7",         1'b0, 32'd6,        32'd7,        32'd0,        32'd6,        1'b0, 1'b0};
      vecs[10] = '{"s 0/-5",        1'b1, 32'd0,        32'hFFFFFFFB, 32'd0,        32'd0,        1'b0, 1'b0};
      vecs[11] = '{"s -5/0",        1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0};
      vecs[12] = '{"u max/16",      1'b0, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 32'd15,       1'b0, 1'b0};

      reset      = 1'b1;
      start      = 1'b0;
      ctl_signed = 1'b0;
      a          = '0;
      b          = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset quotient", quotient, 32'd0);
      check("reset remainder", remainder, 32'd0);
      check("reset flags", {30'd0, div_zero, overflow}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         run_vec(vecs[i]);
      end

      // Second start at edge k+5 must be ignored.
      launch(1'b0, 32'd100, 32'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      ctl_signed = 1'b1;
      a          = 32'd50;
      b          = 32'hFFFFFFFB;
      start      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(5, n, bok);
      check("ignored start latency", n, LATENCY);
      check("ignored start busy", {31'd0, bok}, 32'd1);
      check("ignored start quotient", quotient, 32'd14);
      check("ignored start remainder", remainder, 32'd2);

      // Reset at edge k+10 aborts with no done pulse.
      launch(1'b1, 32'hFFFFFFF9, 32'd2);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort quotient", quotient, 32'd0);
      check("abort remainder", remainder, 32'd0);
      check("abort flags", {30'd0, div_zero, overflow}, 32'd0);
      reset     = 1'b0;
      done_seen = 0;
      for (int i = 0; i < LATENCY + 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("abort no done", done_seen, 0);

      // Start coinciding with reset is dropped.
      @(negedge clk);
      reset      = 1'b1;
      start      = 1'b1;
      ctl_signed = 1'b0;
      a          = 32'd9;
      b          = 32'd3;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("start with reset ignored", {31'd0, busy}, 32'd0);

      // Fresh operation after the abort.
      run_vec(vecs[1]);
      run_vec(vecs[5]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_seq_divider32
